// File: rtl/mont_exp_ctrl_pkg.sv
// Shared definitions for the Montgomery exponentiation controller:
// datapath width, FSM state and multiplier-operation encodings.
package mont_exp_ctrl_pkg;

  localparam int MONT_W = 381;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3,
    FIN   = 3'd4
  } state_t;

  typedef enum logic {
    SQR = 1'b0,
    MUL = 1'b1
  } op_t;

  // Exponent index width; a 1-bit exponent still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Start/done/out_read handshake between the exponentiation controller
// (master) and one Montgomery multiplier instance (slave).
interface mont_exp_ctrl_if
  import mont_exp_ctrl_pkg::*;
#(
  parameter int W = MONT_W
);

  logic         mm_start;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic [W-1:0] mm_m;
  logic         mm_out_read;
  logic [W-1:0] mm_result;
  logic         mm_done;

  modport master (
    output mm_start, mm_a, mm_b, mm_m, mm_out_read,
    input  mm_result, mm_done
  );

  modport slave (
    input  mm_start, mm_a, mm_b, mm_m, mm_out_read,
    output mm_result, mm_done
  );

endinterface

// File: rtl/mont_exp_ctrl.sv
// Constant-time left-to-right square-and-multiply sequencer: acc = x^e mod m
// in Montgomery form, issuing 2*EBITS calls to an external multiplier.
module mont_exp_ctrl
  import mont_exp_ctrl_pkg::*;
#(
  parameter int W     = MONT_W,
  parameter int EBITS = MONT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [W-1:0]     in_x,
  input  logic [EBITS-1:0] in_e,
  input  logic [W-1:0]     in_m,
  input  logic [W-1:0]     in_one,
  input  logic             out_read,
  output logic [W-1:0]     result,
  output logic             done,
  mont_exp_ctrl_if.master  mm
);

  localparam int IDXW = idx_w(EBITS);

  state_t           state, state_nx;
  op_t              op;
  logic [W-1:0]     acc;
  logic [W-1:0]     x;
  logic [W-1:0]     m;
  logic [EBITS-1:0] e;
  logic [IDXW-1:0]  idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (mm.mm_done) state_nx = ACK;
      ACK:     state_nx = (op == MUL && idx == '0) ? FIN : ISSUE;
      FIN:     if (out_read) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operands come straight from registers, so they are stable from ISSUE through ACK.
  always_comb begin
    done           = (state == FIN);
    result         = acc;
    mm.mm_start    = (state == ISSUE);
    mm.mm_out_read = (state == ACK);
    mm.mm_a        = acc;
    mm.mm_b        = (op == SQR) ? acc : x;
    mm.mm_m        = m;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
      x   <= '0;
      m   <= '0;
      e   <= '0;
      idx <= '0;
      op  <= SQR;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= in_one;
            x   <= in_x;
            m   <= in_m;
            e   <= in_e;
            idx <= IDXW'(EBITS - 1);
            op  <= SQR;
          end
        end
        ACK: begin
          if (op == SQR) begin
            acc <= mm.mm_result;
            op  <= MUL;
          end else begin
            // The multiply is always issued; a clear exponent bit just drops its product.
            if (e[idx]) acc <= mm.mm_result;
            op <= SQR;
            if (idx != '0) idx <= idx - IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: a 4-bit-exponent instance and a full 381-bit
// instance, each paired with a behavioural Montgomery multiplier.
module tb_mont_exp_ctrl;
  import mont_exp_ctrl_pkg::*;

  localparam int W = MONT_W;
  localparam int EB_S = 4;
  localparam int EB_B = MONT_W;
  localparam logic [W-1:0] P =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // ---------------- reference arithmetic ----------------
  function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] t;
    t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(t % {{W{1'b0}}, P});
  endfunction

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] v);
    logic [2*W-1:0] t;
    t = {v, {W{1'b0}}};
    return W'(t % {{W{1'b0}}, P});
  endfunction

  function automatic logic [W-1:0] pow_rep(input logic [W-1:0] b, input int unsigned n);
    logic [W-1:0] r;
    r = W'(1);
    repeat (n) r = modmul(r, b);
    return r;
  endfunction

  function automatic logic [W-1:0] pow_bin(input logic [W-1:0] b, input logic [W-1:0] ex);
    logic [W-1:0] r, sq;
    r = W'(1);
    sq = b;
    for (int i = 0; i < W; i++) begin
      if (ex[i]) r = modmul(r, sq);
      sq = modmul(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_fe();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r = (r << 32) | W'($urandom);
    r = r % P;
    if (r == '0) r = W'(1);
    return r;
  endfunction

  // Bit-serial Montgomery product a*b*2^-W mod mm, used by the multiplier models.
  function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] mm);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, mm};
      t = t >> 1;
    end
    if (t >= {2'b00, mm}) t = t - {2'b00, mm};
    return t[W-1:0];
  endfunction

  logic [W-1:0] one_m;
  initial one_m = to_mont(W'(1));

  // ---------------- small instance ----------------
  logic            s_start = 1'b0, s_out_read = 1'b0;
  logic [W-1:0]    s_x = '0;
  logic [EB_S-1:0] s_e = '0;
  logic [W-1:0]    s_result;
  logic            s_done;
  mont_exp_ctrl_if #(.W(W)) ifs ();

  mont_exp_ctrl #(.W(W), .EBITS(EB_S)) dut_s (
    .clk(clk), .resetn(resetn), .start(s_start), .in_x(s_x), .in_e(s_e),
    .in_m(P), .in_one(one_m), .out_read(s_out_read),
    .result(s_result), .done(s_done), .mm(ifs)
  );

  logic [W-1:0] s_prod;
  logic         s_busy, s_done_q;
  int unsigned  s_cnt;
  int unsigned  s_starts = 0, s_acks = 0, s_rises = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ifs.mm_done   <= 1'b0;
      ifs.mm_result <= '0;
      s_busy        <= 1'b0;
      s_cnt         <= 0;
      s_done_q      <= 1'b0;
    end else begin
      s_done_q <= ifs.mm_done;
      if (ifs.mm_done && !s_done_q) s_rises <= s_rises + 1;
      if (ifs.mm_out_read) begin
        s_acks      <= s_acks + 1;
        ifs.mm_done <= 1'b0;
      end
      if (ifs.mm_start) begin
        s_starts <= s_starts + 1;
        s_prod   <= mont_mul(ifs.mm_a, ifs.mm_b, ifs.mm_m);
        s_busy   <= 1'b1;
        s_cnt    <= $urandom_range(0, 3);
      end else if (s_busy) begin
        if (s_cnt == 0) begin
          ifs.mm_done   <= 1'b1;
          ifs.mm_result <= s_prod;
          s_busy        <= 1'b0;
        end else s_cnt <= s_cnt - 1;
      end
    end
  end

  always @(negedge clk)
    if (resetn)
      assert (!ifs.mm_done || dut_s.state == WAIT || dut_s.state == ACK)
        else $error("mm_done seen while controller not waiting on it");

  // ---------------- full-width instance ----------------
  logic            b_start = 1'b0, b_out_read = 1'b0;
  logic [W-1:0]    b_x = '0;
  logic [EB_B-1:0] b_e = '0;
  logic [W-1:0]    b_result;
  logic            b_done;
  mont_exp_ctrl_if #(.W(W)) ifb ();

  mont_exp_ctrl #(.W(W), .EBITS(EB_B)) dut_b (
    .clk(clk), .resetn(resetn), .start(b_start), .in_x(b_x), .in_e(b_e),
    .in_m(P), .in_one(one_m), .out_read(b_out_read),
    .result(b_result), .done(b_done), .mm(ifb)
  );

  logic [W-1:0] b_prod;
  logic         b_busy;
  int unsigned  b_starts = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ifb.mm_done   <= 1'b0;
      ifb.mm_result <= '0;
      b_busy        <= 1'b0;
    end else begin
      if (ifb.mm_out_read) ifb.mm_done <= 1'b0;
      if (ifb.mm_start) begin
        b_starts <= b_starts + 1;
        b_prod   <= mont_mul(ifb.mm_a, ifb.mm_b, ifb.mm_m);
        b_busy   <= 1'b1;
      end else if (b_busy) begin
        ifb.mm_done   <= 1'b1;
        ifb.mm_result <= b_prod;
        b_busy        <= 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_small(input logic [W-1:0] x, input logic [EB_S-1:0] e,
                           output logic [W-1:0] res, output bit ok, output int unsigned calls);
    int unsigned base, n;
    @(negedge clk);
    base = s_starts;
    s_x = x; s_e = e; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (!s_done && n < 500) begin @(negedge clk); n++; end
    ok = s_done;
    res = s_result;
    calls = s_starts - base;
  endtask

  task automatic ack_small();
    s_out_read = 1'b1;
    @(negedge clk);
    s_out_read = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({s_done, ifs.mm_start, ifs.mm_out_read, b_done, ifb.mm_start, ifb.mm_out_read} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000000",
        {s_done, ifs.mm_start, ifs.mm_out_read, b_done, ifb.mm_start, ifb.mm_out_read});
    end
    n_vec++;
    if ((s_result | ifs.mm_a | ifs.mm_b | ifs.mm_m | b_result | ifb.mm_a) !== '0) begin
      n_err++; $display("FAIL reset_data: result/operands not zero (result %h)", s_result);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (s_done !== 1'b0 || ifs.mm_start !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: done=%b mm_start=%b want 0 0", s_done, ifs.mm_start);
    end
  endtask

  task automatic test_e_zero();
    logic [W-1:0] res; bit ok; int unsigned calls;
    run_small(to_mont(rand_fe()), 4'b0000, res, ok, calls);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL e0_timeout: done=0 want 1"); end
    n_vec++;
    if (res !== one_m) begin n_err++; $display("FAIL e0_result: got %h want %h", res, one_m); end
    n_vec++;
    if (calls != 8) begin n_err++; $display("FAIL e0_calls: got %0d want 8", calls); end
    repeat ($urandom_range(3, 8)) @(negedge clk);
    n_vec++;
    if (s_done !== 1'b1 || s_result !== one_m) begin
      n_err++; $display("FAIL e0_hold: done=%b result=%h want 1 %h", s_done, s_result, one_m);
    end
    ack_small();
    n_vec++;
    if (s_done !== 1'b0) begin n_err++; $display("FAIL e0_release: done=%b want 0", s_done); end
  endtask

  task automatic test_e_1011();
    logic [W-1:0] res, exp_v; bit ok; int unsigned calls;
    exp_v = to_mont(pow_rep(W'(3), 11));
    run_small(to_mont(W'(3)), 4'b1011, res, ok, calls);
    n_vec++;
    if (!ok || res !== exp_v) begin
      n_err++; $display("FAIL e1011_result: done=%b got %h want %h", ok, res, exp_v);
    end
    n_vec++;
    if (calls != 8) begin n_err++; $display("FAIL e1011_calls: got %0d want 8", calls); end
    ack_small();
  endtask

  task automatic test_e_0001();
    logic [W-1:0] res, exp_v; bit ok; int unsigned calls, a0, r0;
    exp_v = to_mont(W'(7));
    a0 = s_acks; r0 = s_rises;
    run_small(to_mont(W'(7)), 4'b0001, res, ok, calls);
    n_vec++;
    if (!ok || res !== exp_v) begin
      n_err++; $display("FAIL e0001_result: done=%b got %h want %h", ok, res, exp_v);
    end
    @(negedge clk);
    n_vec++;
    if (s_acks - a0 != 8 || s_rises - r0 != 8) begin
      n_err++; $display("FAIL e0001_acks: acks=%0d done_rises=%0d want 8 8", s_acks - a0, s_rises - r0);
    end
    ack_small();
  endtask

  task automatic test_random();
    logic [W-1:0] res, xn, exp_v; bit ok; int unsigned calls;
    logic [EB_S-1:0] e;
    for (int k = 0; k < 6; k++) begin
      xn = rand_fe();
      e = EB_S'($urandom_range(0, 15));
      exp_v = to_mont(pow_rep(xn, int'(e)));
      run_small(to_mont(xn), e, res, ok, calls);
      n_vec++;
      if (!ok || res !== exp_v || calls != 8) begin
        n_err++; $display("FAIL random_e%0d: done=%b calls=%0d got %h want %h", e, ok, calls, res, exp_v);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack_small();
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] xn, exp_v; int unsigned base, n;
    xn = rand_fe();
    exp_v = to_mont(pow_rep(xn, 5));
    @(negedge clk);
    base = s_starts;
    s_x = to_mont(xn); s_e = 4'b0101; s_start = 1'b1;
    n = 0;
    while (!s_done && n < 500) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    n_vec++;
    if (s_done !== 1'b1 || s_starts - base != 8 || s_result !== exp_v) begin
      n_err++; $display("FAIL held_no_restart: done=%b calls=%0d got %h want 1 8 %h",
                        s_done, s_starts - base, s_result, exp_v);
    end
    s_out_read = 1'b1;
    @(negedge clk);
    s_out_read = 1'b0;
    n_vec++;
    if (s_done !== 1'b0) begin n_err++; $display("FAIL held_out_read_wins: done=%b want 0", s_done); end
    @(negedge clk);
    s_start = 1'b0;
    n_vec++;
    if (ifs.mm_start !== 1'b1) begin
      n_err++; $display("FAIL held_resample: mm_start=%b want 1", ifs.mm_start);
    end
    n = 0;
    while (!s_done && n < 500) begin @(negedge clk); n++; end
    n_vec++;
    if (s_done !== 1'b1 || s_result !== exp_v || s_starts - base != 16) begin
      n_err++; $display("FAIL held_second_run: done=%b calls=%0d got %h want 1 16 %h",
                        s_done, s_starts - base, s_result, exp_v);
    end
    ack_small();
  endtask

  task automatic test_out_read_in_wait();
    logic [W-1:0] xn, exp_v; int unsigned base, n;
    xn = rand_fe();
    exp_v = to_mont(pow_rep(xn, 14));
    @(negedge clk);
    base = s_starts;
    s_x = to_mont(xn); s_e = 4'b1110; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (s_starts == base && n < 100) begin @(negedge clk); n++; end
    s_out_read = 1'b1;
    @(negedge clk);
    s_out_read = 1'b0;
    n = 0;
    while (!s_done && n < 500) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    n_vec++;
    if (s_done !== 1'b1 || s_result !== exp_v || s_starts - base != 8) begin
      n_err++; $display("FAIL wait_out_read_ignored: done=%b calls=%0d got %h want 1 8 %h",
                        s_done, s_starts - base, s_result, exp_v);
    end
    ack_small();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res, xn, exp_v; bit ok; int unsigned base, n, calls;
    @(negedge clk);
    base = s_starts;
    s_x = to_mont(rand_fe()); s_e = 4'b1111; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (s_starts - base < 3 && n < 200) begin @(negedge clk); n++; end
    n_vec++;
    if (s_starts - base != 3) begin n_err++; $display("FAIL mid_reach_call3: calls=%0d want 3", s_starts - base); end
    resetn = 1'b0;
    #1;
    n_vec++;
    if ({s_done, ifs.mm_start, ifs.mm_out_read} !== 3'b000 ||
        (s_result | ifs.mm_a | ifs.mm_b | ifs.mm_m) !== '0 || dut_s.state !== IDLE) begin
      n_err++; $display("FAIL mid_reset_outputs: done=%b start=%b ack=%b result=%h want all 0",
                        s_done, ifs.mm_start, ifs.mm_out_read, s_result);
    end
    @(negedge clk);
    resetn = 1'b1;
    xn = rand_fe();
    exp_v = to_mont(pow_rep(xn, 9));
    run_small(to_mont(xn), 4'b1001, res, ok, calls);
    n_vec++;
    if (!ok || res !== exp_v || calls != 8) begin
      n_err++; $display("FAIL mid_fresh_run: done=%b calls=%0d got %h want %h", ok, calls, res, exp_v);
    end
    ack_small();
  endtask

  task automatic test_full_width();
    logic [W-1:0] exp_v, pm2; int unsigned base, n;
    pm2 = P - W'(2);
    exp_v = to_mont(pow_bin(W'(5), pm2));
    @(negedge clk);
    base = b_starts;
    b_x = to_mont(W'(5)); b_e = pm2; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 20000) begin @(negedge clk); n++; end
    n_vec++;
    if (b_done !== 1'b1 || b_result !== exp_v) begin
      n_err++; $display("FAIL full_inverse: done=%b got %h want %h", b_done, b_result, exp_v);
    end
    n_vec++;
    if (b_starts - base != 762) begin n_err++; $display("FAIL full_calls: got %0d want 762", b_starts - base); end
    b_out_read = 1'b1;
    @(negedge clk);
    b_out_read = 1'b0;
    n_vec++;
    if (b_done !== 1'b0) begin n_err++; $display("FAIL full_release: done=%b want 0", b_done); end
  endtask

  initial begin
    test_reset();
    test_e_zero();
    test_e_1011();
    test_e_0001();
    test_random();
    test_start_held();
    test_out_read_in_wait();
    test_reset_mid();
    test_full_width();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
